mem_dump: RTL and testbench
===========================

MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the RAM word width; fixed at 16, two bytes per word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, the RAM address width (1024 words).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first word address, sampled with start.
REQ-007 SHALL have port word_count  input  ADDR_WIDTH+1  number of words to dump (0..1024), sampled with start.
REQ-008 SHALL have port abort  input  1  request to stop at the next word boundary.
REQ-009 SHALL have port mem_re  output  1  RAM read enable.
REQ-010 SHALL have port mem_addr  output  ADDR_WIDTH  RAM read address.
REQ-011 SHALL have port mem_rdata  input  DATA_WIDTH  RAM read data, valid exactly one cycle after mem_re.
REQ-012 SHALL have port out_data  output  8  byte stream data.
REQ-013 SHALL have port out_valid  output  1  byte stream valid.
REQ-014 SHALL have port out_ready  input  1  byte stream ready from the sink.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on completion or abort.

Function
REQ-017 SHALL implement the states IDLE, READ, WAIT, SEND_HI, SEND_LO, SEND_SUM and DONE.
REQ-018 In IDLE, start=1 SHALL latch base_addr into addr, word_count into remaining, clear the abort flag and checksum, and go to READ, or to SEND_SUM when word_count=0.
REQ-019 READ SHALL drive mem_re=1 and mem_addr=addr for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL capture mem_rdata into the word register and go to SEND_HI.
REQ-021 SEND_HI SHALL assert out_valid with out_data=word[15:8]; on out_valid&&out_ready it SHALL XOR the byte into checksum and go to SEND_LO.
REQ-022 SEND_LO SHALL present word[7:0] the same way. On handshake it SHALL decrement remaining and increment addr modulo 2^ADDR_WIDTH. It SHALL then go to SEND_SUM if remaining reaches 0, to DONE if abort was flagged, and otherwise back to READ.
REQ-023 SEND_SUM SHALL present the 8-bit XOR of all bytes sent; on handshake it SHALL go to DONE.
REQ-024 DONE SHALL assert done for one cycle and return to IDLE.
REQ-025 Once out_valid is asserted, out_data SHALL be held stable and out_valid SHALL NOT drop until the handshake completes.
REQ-026 Latency: with out_ready held at 1, the first out_valid SHALL occur 3 cycles after start is sampled, and each word SHALL take 4 cycles.
REQ-027 abort in any busy state SHALL set a sticky flag; the flag SHALL take effect only after the current SEND_LO handshake; no checksum byte SHALL be sent on abort.
REQ-028 abort asserted in the same cycle as start SHALL be ignored.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 When base_addr+word_count exceeds 2^ADDR_WIDTH, the address SHALL wrap from 1023 to 0.
REQ-031 With word_count=1024, the block SHALL dump every word exactly once.
REQ-032 mem_re SHALL be 0 in every state other than READ.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE and clear busy, done, out_valid, mem_re, out_data, mem_addr, the checksum and the abort flag.
REQ-034 Reset mid-dump SHALL abandon the transfer without a done pulse; the first start after rst_n rises SHALL behave normally.

Verification
REQ-035 Case 1: RAM[0]=0x0001, RAM[1]=0x002A, start with base=0, count=2, out_ready=1 -> bytes 00 01 00 2A 2B, then done pulse, busy=0.
REQ-036 Case 2: start with count=0 -> single byte 00, then done.
REQ-037 Case 3: base=1023, count=2, RAM[1023]=0x1234, RAM[0]=0x0001 -> mem_addr sequence 1023, 0; bytes 12 34 00 01 27.
REQ-038 Case 4: run case 1 with out_ready toggled pseudo-randomly -> identical byte sequence; out_data stable while out_valid=1 and out_ready=0.
REQ-039 Case 5: count=4, abort pulsed during the first SEND_HI -> exactly 2 bytes emitted, no checksum byte, done pulse; a second start during the dump is ignored.
REQ-040 Case 6: rst_n pulsed low during SEND_LO -> out_valid and busy drop immediately, no done pulse; a subsequent rerun of case 1 passes.

Source files
------------

// File: rtl/mem_dump.sv
// RAM-to-byte-stream dumper: reads a run of 16-bit words, emits each as
// high byte then low byte, and closes with an XOR checksum byte.
module mem_dump #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND_HI,
    S_SEND_LO,
    S_SEND_SUM,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [DATA_WIDTH-1:0] r_word;
  logic [7:0]            r_sum;
  logic [7:0]            r_out_data;
  logic                  r_out_valid;
  logic                  r_mem_re;
  logic                  r_abort;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_handshake;
  logic [7:0]            w_sum_next;
  logic                  w_abort_now;
  logic                  w_last_word;

  assign w_handshake = r_out_valid & out_ready;
  assign w_sum_next  = r_sum ^ r_out_data;
  assign w_abort_now = r_abort | abort;
  assign w_last_word = (r_remaining == REM_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_sum       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_mem_re    <= 1'b0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only by the state that owns them.
      r_mem_re <= 1'b0;
      r_done   <= 1'b0;
      if (r_busy && abort) r_abort <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= word_count;
            r_abort     <= 1'b0;
            r_sum       <= '0;
            r_busy      <= 1'b1;
            if (word_count == '0) begin
              r_state     <= S_SEND_SUM;
              r_out_data  <= '0;
              r_out_valid <= 1'b1;
            end else begin
              r_state  <= S_READ;
              r_mem_re <= 1'b1;
            end
          end
        end
        S_READ: r_state <= S_WAIT;
        S_WAIT: begin
          r_word      <= mem_rdata;
          r_out_data  <= mem_rdata[15:8];
          r_out_valid <= 1'b1;
          r_state     <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (w_handshake) begin
            r_sum      <= w_sum_next;
            r_out_data <= r_word[7:0];
            r_state    <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (w_handshake) begin
            r_sum       <= w_sum_next;
            r_remaining <= r_remaining - REM_ONE;
            r_addr      <= r_addr + ADDR_ONE;
            // An aborted dump never emits a checksum, even on its last word.
            if (w_abort_now) begin
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else if (w_last_word) begin
              r_out_data <= w_sum_next;
              r_state    <= S_SEND_SUM;
            end else begin
              r_out_valid <= 1'b0;
              r_mem_re    <= 1'b1;
              r_state     <= S_READ;
            end
          end
        end
        S_SEND_SUM: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_re    = r_mem_re;
  assign mem_addr  = r_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mem_dump.sv
// Directed bench for mem_dump: expected bytes and read addresses are queued
// by the stimulus and consumed by a negedge monitor watching the DUT.
module tb_mem_dump;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] word_count;
  logic        abort;
  logic        mem_re;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [15:0] ram [0:1023];

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  logic [7:0] exp_bytes [$];
  logic [9:0] exp_addrs [$];

  int          ready_mode = 0;
  logic        ready_manual = 1'b0;
  logic [15:0] ready_pat = 16'b0110_1001_1100_0101;
  int          ready_idx = 0;

  logic       mon_stall = 1'b0;
  logic [7:0] mon_data  = '0;

  mem_dump #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .abort     (abort),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_rdata <= ram[mem_addr];

  always @(posedge clk) begin
    #1 ready_idx = (ready_idx + 1) % 16;
  end

  assign out_ready = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 1) ? ready_pat[ready_idx[3:0]] : ready_manual;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_stall = 1'b0;
    end else begin
      if (mon_stall) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_data", {24'b0, out_data}, {24'b0, mon_data});
      end
      if (out_valid && out_ready) begin
        if (exp_bytes.size() == 0) check("unexpected_byte", {24'b0, out_data}, 32'hFFFF_FFFF);
        else check("byte", {24'b0, out_data}, {24'b0, exp_bytes.pop_front()});
      end
      mon_stall = out_valid && !out_ready;
      mon_data  = out_data;
      if (mem_re) begin
        if (exp_addrs.size() == 0) check("unexpected_mem_re", {22'b0, mem_addr}, 32'hFFFF_FFFF);
        else check("mem_addr", {22'b0, mem_addr}, {22'b0, exp_addrs.pop_front()});
      end
      if (done) n_done++;
    end
  end

  task automatic start_dump(input logic [9:0] b, input logic [10:0] c, input logic ab);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = c; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 1;
    while (!out_valid && cycles < budget) begin
      @(posedge clk); #1; cycles++;
    end
    if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int c0, input int budget, output int cycles);
    cycles = c0;
    while (!done && cycles < budget) begin
      @(posedge clk); #1; cycles++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_case(input string name, input int done_before);
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    check({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
    check({name, "_done_count"}, n_done - done_before, 32'd1);
    check({name, "_bytes_left"}, exp_bytes.size(), 32'd0);
    check({name, "_addrs_left"}, exp_addrs.size(), 32'd0);
  endtask

  task automatic run_case1(input string name);
    int cyc;
    int d0;
    d0 = n_done;
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h2A);
    exp_bytes.push_back(8'h2B);
    exp_addrs.push_back(10'd0); exp_addrs.push_back(10'd1);
    start_dump(10'd0, 11'd2, 1'b0);
    wait_valid(20, cyc);
    check({name, "_first_valid_latency"}, cyc, 32'd3);
    wait_done(cyc, 40, cyc);
    check({name, "_start_to_done"}, cyc, 32'd10);
    finish_case(name, d0);
  endtask

  initial begin
    int cyc;
    int d0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; abort = 1'b0;
    for (int i = 0; i < 1024; i++) ram[i] = 16'hDEAD;
    ram[0] = 16'h0001; ram[1] = 16'h002A; ram[1023] = 16'h1234;

    repeat (2) @(posedge clk); #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mem_re", {31'b0, mem_re}, 32'd0);
    check("rst_out_data", {24'b0, out_data}, 32'd0);
    check("rst_mem_addr", {22'b0, mem_addr}, 32'd0);
    rst_n = 1'b1;

    // Case 1: two words, sink always ready.
    run_case1("case1");

    // Case 2: zero words gives only the zero checksum.
    d0 = n_done;
    exp_bytes.push_back(8'h00);
    start_dump(10'd7, 11'd0, 1'b0);
    wait_done(1, 20, cyc);
    check("case2_start_to_done", cyc, 32'd2);
    finish_case("case2", d0);

    // Case 3: address wraps 1023 -> 0; abort alongside start is ignored.
    d0 = n_done;
    exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h34);
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h27);
    exp_addrs.push_back(10'd1023); exp_addrs.push_back(10'd0);
    start_dump(10'd1023, 11'd2, 1'b1);
    wait_done(1, 40, cyc);
    check("case3_start_to_done", cyc, 32'd10);
    finish_case("case3", d0);

    // Case 4: case 1 with a stalling sink.
    d0 = n_done;
    ready_mode = 1;
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h2A);
    exp_bytes.push_back(8'h2B);
    exp_addrs.push_back(10'd0); exp_addrs.push_back(10'd1);
    start_dump(10'd0, 11'd2, 1'b0);
    wait_done(1, 200, cyc);
    finish_case("case4", d0);
    ready_mode = 0;

    // Case 5: abort during the first high byte, plus a second start mid-dump.
    d0 = n_done;
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h01);
    exp_addrs.push_back(10'd0);
    start_dump(10'd0, 11'd4, 1'b0);
    wait_valid(20, cyc);
    abort = 1'b1; start = 1'b1; base_addr = 10'd9; word_count = 11'd1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    wait_done(cyc + 1, 40, cyc);
    check("case5_start_to_done", cyc, 32'd5);
    finish_case("case5", d0);
    repeat (4) @(posedge clk); #1;
    check("case5_stays_idle", {31'b0, busy}, 32'd0);

    // Case 6: reset while the low byte is pending, then rerun case 1.
    d0 = n_done;
    ready_mode = 2; ready_manual = 1'b0;
    exp_bytes.push_back(8'h00);
    exp_addrs.push_back(10'd0);
    start_dump(10'd0, 11'd2, 1'b0);
    wait_valid(20, cyc);
    ready_manual = 1'b1;
    @(posedge clk); #1;
    ready_manual = 1'b0;
    check("case6_lo_pending", {31'b0, out_valid}, 32'd1);
    check("case6_lo_byte", {24'b0, out_data}, 32'h01);
    #2 rst_n = 1'b0;
    #1;
    check("case6_valid_drop", {31'b0, out_valid}, 32'd0);
    check("case6_busy_drop", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    check("case6_no_done", n_done - d0, 32'd0);
    check("case6_bytes_left", exp_bytes.size(), 32'd0);
    ready_mode = 0;
    run_case1("case6_rerun");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
